// File: rtl/cplx_integrate_dump.sv
// cplx_integrate_dump: complex integrate-and-dump of N=ilen+1 valid I/Q samples per block.
// Define CPLX_INTDUMP_SAT_EN for saturating adds with a sticky oover flag; otherwise adds wrap.
module cplx_integrate_dump #(
  parameter int pIDAT_W = 16,
  parameter int pODAT_W = 24,
  parameter int pLEN_W  = 8
) (
  input  logic                      iclk,
  input  logic                      ireset,
  input  logic                      iclkena,
  input  logic [pLEN_W-1:0]         ilen,
  input  logic                      isop,
  input  logic                      ival,
  input  logic signed [pIDAT_W-1:0] idat_re,
  input  logic signed [pIDAT_W-1:0] idat_im,
  output logic                      oval,
  output logic signed [pODAT_W-1:0] odat_re,
  output logic signed [pODAT_W-1:0] odat_im,
  output logic                      oover
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state;
  logic signed [pODAT_W-1:0] r_acc_re, r_acc_im, w_base_re, w_base_im;
  logic signed [pODAT_W-1:0] w_ext_re, w_ext_im, w_sum_re, w_sum_im;
  logic [pLEN_W:0] r_cnt, r_n, w_cnt, w_n, w_len;
  logic r_sticky, w_sticky, w_ovf, w_dump, w_take;

  // An isop sample restarts the block from an empty accumulator.
  assign w_take    = ival & (isop | (r_state == RUN));
  assign w_base_re = isop ? '0 : r_acc_re;
  assign w_base_im = isop ? '0 : r_acc_im;
  assign w_ext_re  = pODAT_W'(idat_re);
  assign w_ext_im  = pODAT_W'(idat_im);
  assign w_len     = {1'b0, ilen} + (pLEN_W+1)'(1);
  assign w_cnt     = (isop ? '0 : r_cnt) + (pLEN_W+1)'(1);
  assign w_n       = isop ? w_len : r_n;
  assign w_dump    = w_cnt == w_n;

`ifdef CPLX_INTDUMP_SAT_EN
  logic [pODAT_W:0] w_wide_re, w_wide_im;
  logic w_ovf_re, w_ovf_im;
  assign w_wide_re = {w_base_re[pODAT_W-1], w_base_re} + {w_ext_re[pODAT_W-1], w_ext_re};
  assign w_wide_im = {w_base_im[pODAT_W-1], w_base_im} + {w_ext_im[pODAT_W-1], w_ext_im};
  assign w_ovf_re  = w_wide_re[pODAT_W] ^ w_wide_re[pODAT_W-1];
  assign w_ovf_im  = w_wide_im[pODAT_W] ^ w_wide_im[pODAT_W-1];
  // The true sign bit selects which rail to clamp to.
  assign w_sum_re  = w_ovf_re ? {w_wide_re[pODAT_W], {(pODAT_W-1){~w_wide_re[pODAT_W]}}} : w_wide_re[pODAT_W-1:0];
  assign w_sum_im  = w_ovf_im ? {w_wide_im[pODAT_W], {(pODAT_W-1){~w_wide_im[pODAT_W]}}} : w_wide_im[pODAT_W-1:0];
  assign w_ovf     = w_ovf_re | w_ovf_im;
`else
  assign w_sum_re  = w_base_re + w_ext_re;
  assign w_sum_im  = w_base_im + w_ext_im;
  assign w_ovf     = 1'b0;
`endif
  assign w_sticky  = (~isop & r_sticky) | w_ovf;

  always_ff @(posedge iclk or negedge ireset)
    if (!ireset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_n      <= '0;
      r_acc_re <= '0;
      r_acc_im <= '0;
      r_sticky <= 1'b0;
      oval     <= 1'b0;
      odat_re  <= '0;
      odat_im  <= '0;
      oover    <= 1'b0;
    end else if (iclkena) begin
      oval <= w_take & w_dump;
      if (w_take) begin
        r_state  <= RUN;
        r_cnt    <= w_dump ? '0 : w_cnt;
        r_n      <= w_dump ? w_len : w_n;
        r_acc_re <= w_dump ? '0 : w_sum_re;
        r_acc_im <= w_dump ? '0 : w_sum_im;
        r_sticky <= ~w_dump & w_sticky;
      end
      if (w_take & w_dump) begin
        odat_re <= w_sum_re;
        odat_im <= w_sum_im;
        oover   <= w_sticky;
      end
    end
endmodule

// File: tb/tb_cplx_integrate_dump.sv
// tb_cplx_integrate_dump: directed checks of block sums, strobe timing, restart, reset and overflow.
module tb_cplx_integrate_dump;
  logic iclk = 1'b0, ireset, iclkena, isop, ival;
  logic [7:0] ilen;
  logic signed [15:0] idat_re, idat_im;
  logic oval, oover, v18, ov18;
  logic signed [23:0] odat_re, odat_im;
  logic signed [17:0] re18, im18;
  int checks = 0, failures = 0;

  always #5 iclk = ~iclk;

  cplx_integrate_dump dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ilen(ilen), .isop(isop), .ival(ival),
    .idat_re(idat_re), .idat_im(idat_im), .oval(oval), .odat_re(odat_re), .odat_im(odat_im),
    .oover(oover));

  cplx_integrate_dump #(.pODAT_W(18)) u18 (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ilen(ilen), .isop(isop), .ival(ival),
    .idat_re(idat_re), .idat_im(idat_im), .oval(v18), .odat_re(re18), .odat_im(im18),
    .oover(ov18));

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic ena, input logic val, input logic sop, input int re, input int im,
                      input logic exp_v, input string tag);
    iclkena = ena; ival = val; isop = sop; idat_re = 16'(re); idat_im = 16'(im);
    @(posedge iclk); #1;
    chk(tag, oval, exp_v);
  endtask

  initial begin
    ireset = 1'b0; iclkena = 1'b0; ival = 1'b0; isop = 1'b0; ilen = 8'd3;
    idat_re = '0; idat_im = '0;
    #12;
    chk("rst_oval", oval, 0); chk("rst_re", odat_re, 0); chk("rst_im", odat_im, 0); chk("rst_over", oover, 0);
    ireset = 1'b1;
    // N=4 block then back-to-back block of 100s
    step(1, 1, 1, 1, -1, 0, "a1");
    step(1, 1, 0, 2, -2, 0, "a2");
    step(1, 1, 0, 3, -3, 0, "a3");
    step(1, 1, 0, 4, -4, 1, "a4");
    chk("a_re", odat_re, 10); chk("a_im", odat_im, -10); chk("a_over", oover, 0);
    step(1, 1, 0, 100, 0, 0, "b1");
    step(1, 1, 0, 100, 0, 0, "b2");
    step(1, 1, 0, 100, 0, 0, "b3");
    step(1, 1, 0, 100, 0, 1, "b4");
    chk("b_re", odat_re, 400); chk("b_im", odat_im, 0);
    // same block with ival gaps and clock-enable stalls
    step(1, 1, 1, 1, -1, 0, "g1");
    step(1, 0, 0, 77, 77, 0, "g_gap1");
    step(0, 1, 0, 55, 55, 0, "g_ena1");
    step(1, 1, 0, 2, -2, 0, "g2");
    step(0, 0, 0, 0, 0, 0, "g_ena2");
    step(1, 1, 0, 3, -3, 0, "g3");
    step(1, 0, 0, 9, 9, 0, "g_gap2");
    step(1, 1, 0, 4, -4, 1, "g4");
    chk("g_re", odat_re, 10); chk("g_im", odat_im, -10);
    step(0, 1, 0, 8, 8, 1, "g_hold");
    step(1, 0, 0, 0, 0, 0, "g_fall");
    step(1, 0, 0, 0, 0, 0, "g_quiet");
    // isop mid-block discards partial sum
    step(1, 1, 1, 5, 0, 0, "s1");
    step(1, 1, 0, 5, 0, 0, "s2");
    step(1, 1, 1, 1, 0, 0, "s3");
    step(1, 1, 0, 1, 0, 0, "s4");
    step(1, 1, 0, 1, 0, 0, "s5");
    step(1, 1, 0, 1, 0, 1, "s6");
    chk("s_re", odat_re, 4);
    // N=1 echo, ilen change takes effect at the next boundary
    ilen = 8'd0;
    step(1, 1, 1, 7, -3, 1, "e1");
    chk("e1_re", odat_re, 7); chk("e1_im", odat_im, -3);
    step(1, 1, 0, -5, 12, 1, "e2");
    chk("e2_re", odat_re, -5); chk("e2_im", odat_im, 12);
    ilen = 8'd1;
    step(1, 1, 0, 9, 0, 1, "e3");
    chk("e3_re", odat_re, 9);
    step(1, 1, 0, 2, 0, 0, "e4");
    step(1, 1, 0, 3, 0, 1, "e5");
    chk("e5_re", odat_re, 5);
    // asynchronous reset mid-block
    ilen = 8'd3;
    step(1, 1, 1, 1, 1, 0, "r1");
    step(1, 1, 0, 2, 2, 0, "r2");
    #2 ireset = 1'b0;
    #1;
    chk("r_oval", oval, 0); chk("r_re", odat_re, 0); chk("r_im", odat_im, 0);
    #2 ireset = 1'b1;
    step(1, 1, 0, 3, 3, 0, "r3");
    step(1, 1, 0, 4, 4, 0, "r4");
    step(1, 1, 0, 5, 5, 0, "r5");
    step(1, 1, 0, 6, 6, 0, "r6");
    chk("r_re_after", odat_re, 0);
    // overflow: 8 x 32767 into 18-bit accumulator
    ilen = 8'd7;
    step(1, 1, 1, 32767, 0, 0, "o1");
    for (int i = 0; i < 6; i++) step(1, 1, 0, 32767, 0, 0, "o_mid");
    step(1, 1, 0, 32767, 0, 1, "o8");
    chk("o24_re", odat_re, 262136); chk("o24_over", oover, 0);
    chk("o18_val", v18, 1);
`ifdef CPLX_INTDUMP_SAT_EN
    chk("o18_re", re18, 131071); chk("o18_over", ov18, 1);
`else
    chk("o18_re", re18, -8); chk("o18_over", ov18, 0);
`endif
    chk("o18_im", im18, 0);
    step(1, 0, 0, 0, 0, 0, "o_fall");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cplx_integrate_dump.md
# cplx_integrate_dump

Complex integrate-and-dump accumulator that sums N consecutive valid I/Q samples and emits one wide sum per block. It sits directly upstream of the rounding/saturation stage: its wide `odat_re`/`odat_im` feed two rounding instances that scale each sum back to the working bit width. Typical uses are correlator integration, power averaging and decimation in the OFDM receive path.

## Interface
- `pIDAT_W`, 16, input sample width per I/Q component, signed
- `pODAT_W`, 24, accumulator and output width per component, signed; must be ≥ `pIDAT_W`
- `pLEN_W`, 8, width of the dump-length control; block length N = `ilen`+1, range 1..2^`pLEN_W`

- `iclk`, input, 1, clock
- `ireset`, input, 1, reset; **one clock, asynchronous active-low reset**
- `iclkena`, input, 1, global clock enable; all state freezes when low
- `ilen`, input, `pLEN_W`, block length minus one; sampled on a start-of-packet sample and at each block boundary
- `isop`, input, 1, start of packet; qualified by `ival`
- `ival`, input, 1, sample valid
- `idat_re`, `idat_im`, input, `pIDAT_W`, signed sample
- `oval`, output, 1, one-cycle strobe: a block sum is on `odat_*`
- `odat_re`, `odat_im`, output, `pODAT_W`, signed block sum, held between strobes
- `oover`, output, 1, accumulator saturated during the emitted block; valid with `oval`

## Operation
- The active-edge condition is `iclkena & ival`. When `iclkena` is low, nothing changes, including `oval`.
- The block uses two states:
  - **IDLE**: entered on reset. Samples without `isop` are ignored. A sample with `isop` does the following: acc ← sign-extended sample, cnt ← 1, N latched from `ilen`, and the state moves to RUN. If the latched N = 1, the block dumps immediately (see below).
  - **RUN**: each sample adds to `acc` and increments `cnt`.
- **Dump.** On the sample that makes cnt = N:
  - `odat_*` ← acc + sample, `oval` ← 1, `oover` ← the sticky flag from that final addition.
  - acc ← 0, cnt ← 0, sticky flag ← 0, N re-latched from `ilen`.
  - The state stays RUN. The next sample starts a new block with no bubble.
- **`isop` while in RUN.** The partial sum is discarded and no `oval` is produced. The `isop` sample becomes sample 1 of a new block, and N is re-latched.
- **Counter.** `cnt` is `pLEN_W`+1 bits wide, so N = 2^`pLEN_W` is reachable.
- **Arithmetic.** I and Q are independent. Each addition is `pODAT_W` bits signed. The overflow behaviour is set by the configuration macro.

## Timing
- Latency: `oval` rises on the clock edge that registers the N-th valid sample, i.e. one cycle after that sample is presented. It then falls on the next edge where `iclkena` is high.
- `oval` is high for exactly one enabled cycle per block. Back-to-back blocks give one strobe every N valid samples.
- Gaps in `ival` extend integration without changing the result.
- Reset values: `oval`=0, `odat_re`=`odat_im`=0, `oover`=0, acc=0, cnt=0, state IDLE. Reset asserted mid-block discards the block. After release, an `isop` is required to start again.
- A change to `ilen` mid-block has no effect until the next latch point.

## Configuration
- `CPLX_INTDUMP_SAT_EN`
  - **Defined:** each addition clamps to [−2^(`pODAT_W`−1), 2^(`pODAT_W`−1)−1]. A sticky per-block flag records any clamp on either component and is output on `oover` with `oval`.
  - **Undefined:** additions wrap modulo 2^`pODAT_W`, and `oover` is tied to 0.

## Test plan
- N=4 (`ilen`=3): `isop` on the first sample, re=1,2,3,4 and im=−1,−2,−3,−4 → one `oval` after the 4th sample with `odat_re`=10 and `odat_im`=−10. The next 4 samples of re=100 → `odat_re`=400, strobe exactly 4 samples later, no bubble.
- Same stimulus with random `ival` gaps and `iclkena` low periods → identical sums. `oval` is held through an `iclkena`-low cycle, and no extra strobes appear.
- N=4: `isop` again after 2 samples (re=5,5), then re=1,1,1,1 → no strobe for the partial block, then `odat_re`=4.
- `pODAT_W`=18, N=8, re=32767 each:
  - macro defined → `odat_re`=131071, `oover`=1
  - macro undefined → `odat_re`=−8, `oover`=0
- `ilen`=0 → every valid sample is echoed sign-extended with latency 1. `ilen` is changed to 1 mid-stream and takes effect only at the next boundary.
- `ireset` pulsed low mid-block → all outputs 0 immediately. After release, samples without `isop` produce no strobe.
